haz_scoreboard: RTL and testbench

- Parametrised successor to the 5-stage pipeline hazard unit.
- Adds a registered scoreboard for a multi-cycle MUL/DIV unit (MDU) that completes out of order, and a configurable multi-cycle front-end flush.
- Also adds per-operand usage qualification, x0 suppression and a stall performance counter.
- Sits beside the decode stage; drives the operand-forward muxes and the pipeline-register stall/flush controls.

---
 rtl/haz_scoreboard.sv | 143 ++++++++++++++
 tb/tb_haz_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/haz_scoreboard.sv
// Decode-stage hazard unit: operand forwarding, load-use/MDU-scoreboard stalls,
// redirect flushes and a saturating stall counter.
module haz_scoreboard #(
  parameter int ADDR_W      = 5,
  parameter int MDU_MAX_OUT = 4,
  parameter int FLUSH_LEN   = 1,
  parameter int CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] D_ADDR1,
  input  logic [ADDR_W-1:0] D_ADDR2,
  input  logic [ADDR_W-1:0] D_WADDR,
  input  logic              D_USES_RS1,
  input  logic              D_USES_RS2,
  input  logic              D_WE,
  input  logic              D_IS_MDU,
  input  logic              D_IS_JUMP,
  input  logic [ADDR_W-1:0] E_WADDR,
  input  logic              E_WE,
  input  logic              E_IS_LOAD,
  input  logic              E_IS_MDU,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] M_WADDR,
  input  logic              M_WE,
  input  logic              M_IS_LOAD,
  input  logic [ADDR_W-1:0] W_WADDR,
  input  logic              W_WE,
  input  logic              MDU_DONE,
  input  logic [ADDR_W-1:0] MDU_WADDR,
  output logic              STALL,
  output logic              FLUSH_F,
  output logic              FLUSH_E,
  output logic [2:0]        FWD_RS1,
  output logic [2:0]        FWD_RS2,
  output logic              SB_ERR,
  output logic [CNT_W-1:0]  STALL_CNT
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int OCW  = $clog2(MDU_MAX_OUT + 1);

  typedef enum logic [2:0] {
    FWD_RF     = 3'd0,
    FWD_E_ALU  = 3'd1,
    FWD_M_ALU  = 3'd2,
    FWD_M_LOAD = 3'd3,
    FWD_W      = 3'd4
  } fwd_sel_e;

  logic [NREG-1:0]   sb_q;
  logic [OCW-1:0]    out_cnt_q;
  logic [2:0]        flush_cnt_q;
  logic              sb_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic [ADDR_W-1:0] src [2];
  logic [1:0]        uses;
  fwd_sel_e          fwd [2];
  logic              load_use, raw, waw, structural;
  logic              stall, jump_go, redirect;
  logic              issue, done_ok, done_bad;

  function automatic logic hit(input logic uses_src, input logic [ADDR_W-1:0] a_src,
                               input logic we, input logic [ADDR_W-1:0] a_dst);
    return uses_src && we && (a_src == a_dst) && (a_src != '0);
  endfunction

  assign src[0] = D_ADDR1;
  assign src[1] = D_ADDR2;
  assign uses   = {D_USES_RS2, D_USES_RS1};

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    load_use = 1'b0;
    raw      = 1'b0;
    for (int n = 0; n < 2; n++) begin
      fwd[n] = FWD_RF;
      if (hit(uses[n], src[n], E_WE, E_WADDR) && !E_IS_LOAD)
        fwd[n] = FWD_E_ALU;
      else if (hit(uses[n], src[n], M_WE, M_WADDR))
        fwd[n] = M_IS_LOAD ? FWD_M_LOAD : FWD_M_ALU;
      else if (hit(uses[n], src[n], W_WE, W_WADDR))
        fwd[n] = FWD_W;
      if (hit(uses[n], src[n], E_WE, E_WADDR) && E_IS_LOAD)
        load_use = 1'b1;
      if (uses[n] && (src[n] != '0) && sb_q[src[n]])
        raw = 1'b1;
    end
  end

  assign waw        = D_WE && (D_WADDR != '0) && sb_q[D_WADDR];
  assign structural = D_IS_MDU && (out_cnt_q == OCW'(MDU_MAX_OUT));
  // A taken branch squashes the decode instruction, so its hazards are moot.
  assign stall      = (load_use || raw || waw || structural) && !BR_TAKEN;
  assign jump_go    = D_IS_JUMP && !stall && !BR_TAKEN;
  assign redirect   = BR_TAKEN || jump_go;

  assign issue    = E_IS_MDU && E_WE && (E_WADDR != '0) && !BR_TAKEN;
  assign done_ok  = MDU_DONE && sb_q[MDU_WADDR] && (out_cnt_q != '0);
  assign done_bad = MDU_DONE && !done_ok;

  assign STALL     = !RST && stall;
  assign FLUSH_E   = !RST && (BR_TAKEN || stall);
  assign FLUSH_F   = !RST && (redirect || (flush_cnt_q != '0));
  assign FWD_RS1   = RST ? FWD_RF : fwd[0];
  assign FWD_RS2   = RST ? FWD_RF : fwd[1];
  assign SB_ERR    = !RST && sb_err_q;
  assign STALL_CNT = RST ? '0 : stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, so clearing it on reset is cheap and required.
      sb_q        <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking writes resolve last-wins, so an issue to the register
      // completing this same cycle leaves its bit set.
      if (done_ok) sb_q[MDU_WADDR] <= 1'b0;
      if (issue)   sb_q[E_WADDR]   <= 1'b1;

      case ({issue, done_ok})
        2'b10:   out_cnt_q <= out_cnt_q + OCW'(1);
        2'b01:   out_cnt_q <= out_cnt_q - OCW'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase

      if (done_bad) sb_err_q <= 1'b1;

      if (redirect)
        flush_cnt_q <= 3'(FLUSH_LEN - 1);
      else if (flush_cnt_q != '0)
        flush_cnt_q <= flush_cnt_q - 3'd1;

      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_haz_scoreboard.sv
// Bench for haz_scoreboard: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the hazard rules.
module tb_haz_scoreboard;

  localparam int ADDR_W      = 5;
  localparam int MDU_MAX_OUT = 2;
  localparam int FLUSH_LEN   = 3;
  localparam int CNT_W       = 8;
  localparam int NREG        = 1 << ADDR_W;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [ADDR_W-1:0] d_addr1, d_addr2, d_waddr, e_waddr, m_waddr, w_waddr, mdu_waddr;
  logic              d_uses_rs1, d_uses_rs2, d_we, d_is_mdu, d_is_jump;
  logic              e_we, e_is_load, e_is_mdu, br_taken, m_we, m_is_load, w_we, mdu_done;
  logic              stall_o, flush_f_o, flush_e_o, sb_err_o;
  logic [2:0]        fwd_rs1_o, fwd_rs2_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  haz_scoreboard #(
    .ADDR_W(ADDR_W), .MDU_MAX_OUT(MDU_MAX_OUT), .FLUSH_LEN(FLUSH_LEN), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk), .RST(rst),
    .D_ADDR1(d_addr1), .D_ADDR2(d_addr2), .D_WADDR(d_waddr),
    .D_USES_RS1(d_uses_rs1), .D_USES_RS2(d_uses_rs2), .D_WE(d_we),
    .D_IS_MDU(d_is_mdu), .D_IS_JUMP(d_is_jump),
    .E_WADDR(e_waddr), .E_WE(e_we), .E_IS_LOAD(e_is_load), .E_IS_MDU(e_is_mdu),
    .BR_TAKEN(br_taken),
    .M_WADDR(m_waddr), .M_WE(m_we), .M_IS_LOAD(m_is_load),
    .W_WADDR(w_waddr), .W_WE(w_we),
    .MDU_DONE(mdu_done), .MDU_WADDR(mdu_waddr),
    .STALL(stall_o), .FLUSH_F(flush_f_o), .FLUSH_E(flush_e_o),
    .FWD_RS1(fwd_rs1_o), .FWD_RS2(fwd_rs2_o),
    .SB_ERR(sb_err_o), .STALL_CNT(stall_cnt_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit pend [NREG];
  int outstanding = 0;
  int flush_left  = 0;
  bit err_m       = 0;
  int stall_total = 0;

  // Outputs sampled by the most recent step
  logic             s_stall, s_fe, s_ff, s_err;
  logic [2:0]       s_fwd1, s_fwd2;
  logic [CNT_W-1:0] s_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_fwd(input bit uses_src, input int a);
    if (!uses_src || a == 0)            return 0;
    if (e_we && int'(e_waddr) == a && !e_is_load) return 1;
    if (m_we && int'(m_waddr) == a)     return m_is_load ? 3 : 2;
    if (w_we && int'(w_waddr) == a)     return 4;
    return 0;
  endfunction

  task automatic idle();
    rst = 1'b0;
    {d_addr1, d_addr2, d_waddr, e_waddr, m_waddr, w_waddr, mdu_waddr} = '0;
    {d_uses_rs1, d_uses_rs2, d_we, d_is_mdu, d_is_jump} = '0;
    {e_we, e_is_load, e_is_mdu, br_taken, m_we, m_is_load, w_we, mdu_done} = '0;
  endtask

  // Called just after a rising edge with inputs set; checks at the falling edge,
  // then advances the model across the next rising edge.
  task automatic step();
    bit lu, raw, waw, full, stl, redir, done_ok, issue;
    @(negedge clk);
    lu   = (d_uses_rs1 && d_addr1 != 0 && e_we && e_waddr == d_addr1 && e_is_load) ||
           (d_uses_rs2 && d_addr2 != 0 && e_we && e_waddr == d_addr2 && e_is_load);
    raw  = (d_uses_rs1 && d_addr1 != 0 && pend[d_addr1]) ||
           (d_uses_rs2 && d_addr2 != 0 && pend[d_addr2]);
    waw  = d_we && d_waddr != 0 && pend[d_waddr];
    full = d_is_mdu && outstanding == MDU_MAX_OUT;
    stl  = !br_taken && (lu || raw || waw || full);
    redir = br_taken || (d_is_jump && !stl);

    s_stall = stall_o; s_fe = flush_e_o; s_ff = flush_f_o; s_err = sb_err_o;
    s_fwd1 = fwd_rs1_o; s_fwd2 = fwd_rs2_o; s_cnt = stall_cnt_o;

    if (rst) begin
      check("rst_stall",   s_stall, 0);
      check("rst_flush_e", s_fe, 0);
      check("rst_flush_f", s_ff, 0);
      check("rst_fwd1",    s_fwd1, 0);
      check("rst_fwd2",    s_fwd2, 0);
      check("rst_sb_err",  s_err, 0);
      check("rst_cnt",     s_cnt, 0);
      foreach (pend[i]) pend[i] = 0;
      outstanding = 0; flush_left = 0; err_m = 0; stall_total = 0;
    end else begin
      check("stall",     s_stall, stl);
      check("flush_e",   s_fe, br_taken || stl);
      check("flush_f",   s_ff, redir || flush_left > 0);
      check("fwd_rs1",   s_fwd1, ref_fwd(d_uses_rs1, int'(d_addr1)));
      check("fwd_rs2",   s_fwd2, ref_fwd(d_uses_rs2, int'(d_addr2)));
      check("sb_err",    s_err, err_m);
      check("stall_cnt", s_cnt, stall_total);

      done_ok = mdu_done && pend[mdu_waddr] && outstanding > 0;
      issue   = e_is_mdu && e_we && e_waddr != 0 && !br_taken;
      if (mdu_done && !done_ok) err_m = 1;
      if (done_ok) begin pend[mdu_waddr] = 0; outstanding--; end
      if (issue)   begin pend[e_waddr]   = 1; outstanding++; end
      if (redir)               flush_left = FLUSH_LEN - 1;
      else if (flush_left > 0) flush_left--;
      if (stl && stall_total < CNT_MAX) stall_total++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_mdu(input int rd);
    idle(); e_is_mdu = 1; e_we = 1; e_waddr = ADDR_W'(rd);
    step();
  endtask

  task automatic random_cycle();
    int q[$];
    bit plan_ok;
    idle();
    rst        = ($urandom_range(0, 199) == 0);
    d_addr1    = ADDR_W'($urandom_range(0, 7));
    d_addr2    = ADDR_W'($urandom_range(0, 7));
    d_waddr    = ADDR_W'($urandom_range(0, 7));
    d_uses_rs1 = ($urandom_range(0, 1) == 0);
    d_uses_rs2 = ($urandom_range(0, 1) == 0);
    d_we       = ($urandom_range(0, 1) == 0);
    d_is_mdu   = ($urandom_range(0, 3) == 0);
    d_is_jump  = ($urandom_range(0, 9) == 0);
    e_waddr    = ADDR_W'($urandom_range(0, 7));
    e_we       = ($urandom_range(0, 1) == 0);
    e_is_load  = ($urandom_range(0, 3) == 0);
    br_taken   = ($urandom_range(0, 11) == 0);
    m_waddr    = ADDR_W'($urandom_range(0, 7));
    m_we       = ($urandom_range(0, 1) == 0);
    m_is_load  = ($urandom_range(0, 2) == 0);
    w_waddr    = ADDR_W'($urandom_range(0, 7));
    w_we       = ($urandom_range(0, 1) == 0);
    foreach (pend[i]) if (pend[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
      mdu_done  = 1;
      mdu_waddr = ADDR_W'(q[$urandom_range(0, q.size() - 1)]);
    end else if ($urandom_range(0, 79) == 0) begin
      mdu_done  = 1;
      mdu_waddr = ADDR_W'($urandom_range(0, 15));
    end
    plan_ok = mdu_done && pend[mdu_waddr];
    // Only issue MDU ops that a working pipeline could have let through decode.
    if ($urandom_range(0, 2) == 0 && e_waddr != 0 &&
        outstanding - int'(plan_ok) < MDU_MAX_OUT &&
        (!pend[e_waddr] || (plan_ok && mdu_waddr == e_waddr))) begin
      e_is_mdu = 1; e_we = 1; e_is_load = 0;
    end
    step();
  endtask

  initial begin
    logic [CNT_W-1:0] c0;
    idle();
    @(posedge clk); #1;

    // Reset with active decode traffic: every output must read zero
    rst = 1; d_uses_rs1 = 1; d_addr1 = 5; e_we = 1; e_waddr = 5; d_is_jump = 1;
    step();
    check("tp_rst_fwd1", s_fwd1, 0);
    step();

    // ALU forward from E, and x0 suppression
    idle(); e_we = 1; e_waddr = 5; d_uses_rs1 = 1; d_addr1 = 5;
    step();
    check("tp_fwd_e", s_fwd1, 1);
    e_waddr = 0; d_addr1 = 0;
    step();
    check("tp_x0_fwd", s_fwd1, 0);
    check("tp_x0_stall", s_stall, 0);

    // Load-use stall, then load data forwarded from M
    idle(); e_we = 1; e_is_load = 1; e_waddr = 7; d_uses_rs2 = 1; d_addr2 = 7;
    step();
    check("tp_lu_stall", s_stall, 1);
    check("tp_lu_fe", s_fe, 1);
    idle(); m_we = 1; m_is_load = 1; m_waddr = 7; d_uses_rs2 = 1; d_addr2 = 7;
    step();
    check("tp_lu_fwd_m", s_fwd2, 3);
    check("tp_lu_release", s_stall, 0);

    // MUL x9: consumer stalls through the completion cycle inclusive
    issue_mdu(9);
    c0 = s_cnt;
    idle(); d_uses_rs1 = 1; d_addr1 = 9;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tp_mul_wait", s_stall, 1);
    end
    mdu_done = 1; mdu_waddr = 9;
    step();
    check("tp_mul_done_cycle", s_stall, 1);
    idle(); d_uses_rs1 = 1; d_addr1 = 9;
    step();
    check("tp_mul_after", s_stall, 0);
    check("tp_mul_cnt_delta", s_cnt - c0, 4);

    // Structural limit with out-of-order completion
    issue_mdu(3);
    issue_mdu(4);
    idle(); d_is_mdu = 1;
    step();
    check("tp_struct_full", s_stall, 1);
    mdu_done = 1; mdu_waddr = 4;
    step();
    check("tp_struct_done_cycle", s_stall, 1);
    idle(); d_is_mdu = 1;
    step();
    check("tp_struct_release", s_stall, 0);
    idle(); d_uses_rs1 = 1; d_addr1 = 3;
    step();
    check("tp_x3_pending", s_stall, 1);
    idle(); mdu_done = 1; mdu_waddr = 3;
    step();

    // Branch overrides a load-use stall; flush lasts FLUSH_LEN cycles
    idle(); e_we = 1; e_is_load = 1; e_waddr = 7; d_uses_rs1 = 1; d_addr1 = 7; br_taken = 1;
    step();
    check("tp_br_stall", s_stall, 0);
    check("tp_br_fe", s_fe, 1);
    check("tp_br_ff0", s_ff, 1);
    idle();
    step(); check("tp_br_ff1", s_ff, 1);
    step(); check("tp_br_ff2", s_ff, 1);
    step(); check("tp_br_ff3", s_ff, 0);

    // Jump alone
    idle(); d_is_jump = 1;
    step();
    check("tp_jmp_ff0", s_ff, 1);
    check("tp_jmp_fe", s_fe, 0);
    idle();
    step(); check("tp_jmp_ff1", s_ff, 1);
    step(); check("tp_jmp_ff2", s_ff, 1);
    step(); check("tp_jmp_ff3", s_ff, 0);

    // Completion with an empty scoreboard: sticky error, count unchanged
    idle(); mdu_done = 1; mdu_waddr = 12;
    step();
    idle();
    step();
    check("tp_sb_err", s_err, 1);
    issue_mdu(3);
    issue_mdu(4);
    idle(); d_is_mdu = 1;
    step();
    check("tp_err_count_kept", s_stall, 1);

    // Reset with pending ops discards everything
    idle(); rst = 1; d_uses_rs1 = 1; d_addr1 = 3;
    step();
    idle(); d_uses_rs1 = 1; d_addr1 = 3; d_is_mdu = 1;
    step();
    check("tp_post_rst_stall", s_stall, 0);
    check("tp_post_rst_err", s_err, 0);
    check("tp_post_rst_cnt", s_cnt, 0);

    // Stall counter saturation
    issue_mdu(6);
    idle(); d_uses_rs1 = 1; d_addr1 = 6;
    repeat (CNT_MAX + 5) step();
    check("tp_cnt_sat", s_cnt, CNT_MAX);
    idle(); mdu_done = 1; mdu_waddr = 6;
    step();

    // Random traffic against the model
    repeat (3000) random_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
